// File: rtl/regfile_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regarb_pkg
//   Shared constants and types for the register-file read-port arbiter.
//   DATA_W / ADDR_W    : register width and register index width
//   MAX_REQ / MAX_ID_W : upper bound on requesters and the ID width that holds it
//   XZR_IDX            : index of the zero register (used when REGARB_XZR_EN is set)
//   rd_req_t           : captured read request (address + owning requester ID)
//   s1_state_t         : occupancy state of the first pipeline stage
// -----------------------------------------------------------------------------
package regarb_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

    // The ID field is sized for the largest legal requester count so one type
    // serves every NUM_REQ; narrower instances use the low ID_W bits.
    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [MAX_ID_W-1:0] id;
    } rd_req_t;

    typedef enum logic {
        S1_EMPTY = 1'b0,
        S1_FULL  = 1'b1
    } s1_state_t;

    function automatic logic is_xzr(input logic [ADDR_W-1:0] addr);
        return addr == XZR_IDX;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter_if
//   Bundles the requester handshake, the register-file select/data pair and the
//   tagged response of the read-port arbiter.
//   slave  modport : the arbiter (inputs req_valid/req_addr/stall/flush/rf_data,
//                    outputs req_ready/rf_sel/rsp_valid/rsp_id/rsp_data/s1_state)
//   master modport : requesters, register file and observers (mirror image)
//
//   Handshake: requester k raises req_valid[k] with req_addr slice k; the read is
//   accepted in any cycle where req_valid[k] && req_ready[k]. While valid is high
//   and ready is low the address must stay stable; valid may drop without effect.
//   Responses are single-cycle rsp_valid pulses with no back-pressure.
// -----------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import regarb_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      stall;
    logic                      flush;
    logic [ADDR_W-1:0]         rf_sel;
    logic [DATA_W-1:0]         rf_data;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    s1_state_t                 s1_state;   // debug view of stage-1 occupancy

    modport slave (
        input  req_valid, req_addr, stall, flush, rf_data,
        output req_ready, rf_sel, rsp_valid, rsp_id, rsp_data, s1_state
    );

    modport master (
        output req_valid, req_addr, stall, flush, rf_data,
        input  req_ready, rf_sel, rsp_valid, rsp_id, rsp_data, s1_state
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Searches req_i starting at ptr_i and wrapping
//   modulo NUM_REQ; the first requester found wins. No state: the pointer register
//   lives in the parent.
//   req_i     : request vector
//   ptr_i     : highest-priority requester this cycle (0..NUM_REQ-1)
//   en_i      : grant enable; when low no grant is issued
//   gnt_o     : one-hot grant (all zero when nothing granted)
//   gnt_idx_o : index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr + i cannot overflow before the modulo fold.
            sum  = {1'b0, ptr_i} + (ID_W+1)'(i);
            cand = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                               : ID_W'(sum);
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//   Shares the single register-file read port between NUM_REQ requesters.
//   Round-robin grant, one accept per cycle, fixed 2-cycle pipelined response
//   tagged with the requester ID.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : regfile_read_arbiter_if.slave (requests, grant, stall/flush,
//           rf_sel/rf_data, response, stage-1 debug state)
//
//   Pipeline: accept in cycle N -> stage 1 drives rf_sel in N+1 -> response
//   registered at the end of N+1 -> rsp_valid high in cycle N+2 only.
//   stall blocks grants only; flush blocks grants and kills both stages.
//
//   Build option REGARB_XZR_EN: register 31 reads as zero (rf_sel still 31,
//   latency unchanged). Without it all addresses return rf_data.
// -----------------------------------------------------------------------------
module regfile_read_arbiter
    import regarb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic                    clk,
    input logic                    reset,
    regfile_read_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    s1_state_t          s1_state_q, s1_state_d;
    rd_req_t            s1_q, s1_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               grant_en;
    logic               accept;
    logic               s1_v;

    // flush wins over stall; either one suppresses new grants.
    assign grant_en = !bus.stall && !bus.flush;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .en_i      (grant_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // The arbiter only grants a valid requester, so any grant bit is an accept.
    assign accept        = |gnt;
    assign bus.req_ready = gnt;

    always_comb begin
        gnt_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gnt_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pointer moves just past the winner; held when nothing is accepted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Stage 1: EMPTY/FULL purely follows whether this cycle accepted. The captured
    // address is kept when idle so rf_sel does not toggle.
    always_comb begin
        s1_state_d = s1_state_q;
        s1_d       = s1_q;
        case (s1_state_q)
            S1_EMPTY: s1_state_d = accept ? S1_FULL : S1_EMPTY;
            S1_FULL:  s1_state_d = accept ? S1_FULL : S1_EMPTY;
            default:  s1_state_d = S1_EMPTY;
        endcase
        if (bus.flush) begin
            s1_state_d = S1_EMPTY;
        end
        if (accept) begin
            s1_d.addr = gnt_addr;
            s1_d.id   = MAX_ID_W'(gnt_idx);
        end
    end

    assign s1_v = (s1_state_q == S1_FULL);

    // Stage 2: capture the register value selected by stage 1.
    always_comb begin
        rsp_valid_d = s1_v && !bus.flush;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (s1_v) begin
            rsp_id_d = ID_W'(s1_q.id);
`ifdef REGARB_XZR_EN
            rsp_data_d = is_xzr(s1_q.addr) ? '0 : bus.rf_data;
`else
            rsp_data_d = bus.rf_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            s1_state_q  <= S1_EMPTY;
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_state_q  <= s1_state_d;
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rf_sel    = s1_q.addr;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.s1_state  = s1_state_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//   Bench for regfile_read_arbiter (NUM_REQ=4). A reference model samples every
//   cycle mid-period: it computes the expected round-robin grant from the request
//   vector and its own pointer, and keeps an expected-response queue stamped with
//   the cycle each response is due. Table vectors, hand sequences for multi-cycle
//   corners and a randomized phase all run against that model.
//   Honours REGARB_XZR_EN for the expected data of register 31.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;
    import regarb_pkg::*;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int EXP_W = 16 + ID_W + DATA_W;   // {due cycle, id, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.NUM_REQ(N)) bus ();

    regfile_read_arbiter #(.NUM_REQ(N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [32];
    assign bus.rf_data = mem[bus.rf_sel];

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [EXP_W-1:0] exp_q[$];
    int m_ptr = 0;
    logic [N-1:0] m_acc = '0;
    logic [N-1:0] prev_pend = '0;
    logic [N*ADDR_W-1:0] prev_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_data(input int addr);
`ifdef REGARB_XZR_EN
        if (addr == 31) return '0;
`endif
        return mem[addr];
    endfunction

    // ---------------- reference model + monitor ----------------
    always @(negedge clk) begin : monitor
        logic [N-1:0] m_ready;
        logic [EXP_W-1:0] e;
        logic hit;
        int k;
        int a;
        cyc++;
        if (reset) begin
            exp_q.delete();
            m_ptr = 0;
            m_acc = '0;
            prev_pend = '0;
        end else begin
            hit = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                hit = (e[EXP_W-1 -: 16] == 16'(cyc));
            end
            check("rsp_valid", 64'(bus.rsp_valid), 64'(hit));
            if (hit) begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(bus.rsp_id), 64'(e[DATA_W +: ID_W]));
                check("rsp_data", bus.rsp_data, e[DATA_W-1:0]);
            end
            m_ready = '0;
            if (!bus.stall && !bus.flush) begin
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (m_ready == '0 && bus.req_valid[k]) m_ready[k] = 1'b1;
                end
            end
            check("req_ready", 64'(bus.req_ready), 64'(m_ready));
            for (int q = 0; q < N; q++) begin
                if (prev_pend[q] && bus.req_valid[q] &&
                    bus.req_addr[q*ADDR_W +: ADDR_W] != prev_addr[q*ADDR_W +: ADDR_W]) begin
                    errors++;
                    $display("FAIL addr_stable req%0d cyc=%0d", q, cyc);
                end
            end
            // Anything still queued here is due next cycle, i.e. in flight.
            if (bus.flush) exp_q.delete();
            m_acc = m_ready & bus.req_valid;
            for (int q = 0; q < N; q++) begin
                if (m_acc[q]) begin
                    a = int'(bus.req_addr[q*ADDR_W +: ADDR_W]);
                    exp_q.push_back({16'(cyc + 2), ID_W'(q), ref_data(a)});
                    m_ptr = (q + 1) % N;
                end
            end
            prev_pend = bus.req_valid & ~m_ready;
            prev_addr = bus.req_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [ADDR_W-1:0] a);
        bus.req_valid[k] = v;
        bus.req_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic go_idle();
        bus.req_valid = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_sel"},    64'(bus.rf_sel),    64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
        check({tag, "_rsp_data"},  bus.rsp_data,       64'd0);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_s1_state"},  64'(bus.s1_state),  64'd0);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         stall;
        logic         flush;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t tbl [13];

    logic [DATA_W-1:0] exp_xzr;

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        mem[5]  = 64'hA5;
        mem[31] = 64'hFF;
`ifdef REGARB_XZR_EN
        exp_xzr = 64'h0;
`else
        exp_xzr = 64'hFF;
`endif

        // Grant sequence from a fresh pointer, hand-derived.
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1010, 1'b0, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1011, 1'b0, 1'b0, 4'b1000};
        tbl[3]  = '{4'b1011, 1'b0, 1'b0, 4'b0001};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0000};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0000};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0001, 1'b0, 1'b0, 4'b0001};
        tbl[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0100};
        tbl[9]  = '{4'b0110, 1'b0, 1'b0, 4'b0010};
        tbl[10] = '{4'b0110, 1'b0, 1'b0, 4'b0100};
        tbl[11] = '{4'b1000, 1'b0, 1'b0, 4'b1000};
        tbl[12] = '{4'b1111, 1'b0, 1'b0, 4'b0001};

        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b0;

        // ---- table vectors ----
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 5'(10 + k));
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.stall     = tbl[i].stall;
            bus.flush     = tbl[i].flush;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            tick();
        end
        go_idle();
        repeat (3) tick();

        // ---- reset mid-stream with addr 7 in flight ----
        set_req(0, 1'b1, 5'd7);
        tick();
        reset = 1'b1;
        go_idle();
        @(negedge clk);
        check_all_zero("t1");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_no_rsp", 64'(bus.rsp_valid), 64'd0);
            tick();
        end

        // ---- all four valid for 12 cycles from a fresh pointer ----
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(20 + k));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t3_grant", 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
            tick();
        end
        go_idle();
        repeat (3) tick();

        // ---- single request, latency and tag ----
        set_req(2, 1'b1, 5'd5);
        @(negedge clk);
        check("t2_ready", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        go_idle();
        @(negedge clk);
        check("t2_n1_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t2_n2_valid", 64'(bus.rsp_valid), 64'd1);
        check("t2_id", 64'(bus.rsp_id), 64'd2);
        check("t2_data", bus.rsp_data, 64'hA5);
        tick();
        @(negedge clk);
        check("t2_n3_valid", 64'(bus.rsp_valid), 64'd0);
        tick();

        // ---- back-to-back from requester 0 ----
        set_req(0, 1'b1, 5'd1);
        tick();
        set_req(0, 1'b1, 5'd2);
        @(negedge clk);
        check("t4_sel1", 64'(bus.rf_sel), 64'd1);
        tick();
        set_req(0, 1'b1, 5'd3);
        @(negedge clk);
        check("t4_sel2", 64'(bus.rf_sel), 64'd2);
        check("t4_rsp1", 64'(bus.rsp_valid), 64'd1);
        tick();
        go_idle();
        @(negedge clk);
        check("t4_sel3", 64'(bus.rf_sel), 64'd3);
        check("t4_rsp2", 64'(bus.rsp_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t4_rsp3", 64'(bus.rsp_valid), 64'd1);
        check("t4_sel_hold", 64'(bus.rf_sel), 64'd3);
        tick();
        @(negedge clk);
        check("t4_rsp_end", 64'(bus.rsp_valid), 64'd0);
        check("t4_sel_idle", 64'(bus.rf_sel), 64'd3);
        tick();

        // ---- flush kills the in-flight read ----
        set_req(1, 1'b1, 5'd9);
        @(negedge clk);
        check("t5_ready", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        go_idle();
        bus.flush = 1'b1;
        @(negedge clk);
        check("t5_flush_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        set_req(3, 1'b1, 5'd4);
        @(negedge clk);
        check("t5_killed", 64'(bus.rsp_valid), 64'd0);
        check("t5_next_ready", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        go_idle();
        @(negedge clk);
        check("t5_none", 64'(bus.rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t5_rsp_id", 64'(bus.rsp_id), 64'd3);
        check("t5_rsp_data", bus.rsp_data, mem[4]);
        tick();

        // ---- stall with a read of register 31 in flight ----
        set_req(0, 1'b1, 5'd31);
        tick();
        set_req(0, 1'b0, 5'd31);
        set_req(1, 1'b1, 5'd6);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stall_ready", 64'(bus.req_ready), 64'd0);
            if (i == 1) begin
                check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                check("t6_rsp_id", 64'(bus.rsp_id), 64'd0);
                check("t6_xzr_data", bus.rsp_data, exp_xzr);
            end
            tick();
        end
        bus.stall = 1'b0;
        @(negedge clk);
        check("t6_resume_ready", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        go_idle();
        repeat (3) tick();

        // ---- randomized traffic ----
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < N; k++) begin
                if (bus.req_valid[k] && !m_acc[k]) begin
                    if ($urandom_range(0, 7) == 0) bus.req_valid[k] = 1'b0;
                end else begin
                    bus.req_valid[k] = ($urandom_range(0, 2) != 0);
                    bus.req_addr[k*ADDR_W +: ADDR_W] =
                        ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                end
            end
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        go_idle();
        repeat (4) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
